// File: rtl/nibble_mayor_window_pkg.sv
// rtl/nibble_mayor_window_pkg.sv - shared types and constants for the nibble window max block
// Holds the FSM state encoding, the nibble width and the default window length.
package nibble_mayor_window_pkg;

  localparam int NIBBLE_W       = 4;
  localparam int WINDOW_DEFAULT = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/nibble_mayor_window_if.sv
// rtl/nibble_mayor_window_if.sv - sample-in / result-out handshake bundle
// Ports:
//   nmw_in, nmw_in_valid, nmw_in_ready  - incoming nibble sample stream
//   nmw_max, nmw_idx, nmw_max_valid,
//   nmw_max_ready                       - completed window result
// The master modport is the producer/consumer side; slave is the block itself.
interface nibble_mayor_window_if;
  import nibble_mayor_window_pkg::*;

  nibble_t nmw_in;
  logic    nmw_in_valid;
  logic    nmw_in_ready;
  nibble_t nmw_max;
  nibble_t nmw_idx;
  logic    nmw_max_valid;
  logic    nmw_max_ready;

  modport master (
    output nmw_in, nmw_in_valid, nmw_max_ready,
    input  nmw_in_ready, nmw_max, nmw_idx, nmw_max_valid
  );

  modport slave (
    input  nmw_in, nmw_in_valid, nmw_max_ready,
    output nmw_in_ready, nmw_max, nmw_idx, nmw_max_valid
  );

endinterface

// File: rtl/nibble_max_sel.sv
// rtl/nibble_max_sel.sv - combinational two-nibble maximum selector
// Ports:
//   cur_max  in   current running maximum
//   sample   in   new sample
//   greater  out  the larger of the two (cur_max on a tie)
//   gt       out  sample is strictly greater than cur_max
module nibble_max_sel
  import nibble_mayor_window_pkg::*;
(
  input  nibble_t cur_max,
  input  nibble_t sample,
  output nibble_t greater,
  output logic    gt
);

  // Strict compare so that a tie keeps the earlier holder of the maximum.
  assign gt      = (sample > cur_max);
  assign greater = gt ? sample : cur_max;

endmodule

// File: rtl/nibble_mayor_window.sv
// rtl/nibble_mayor_window.sv - maximum nibble and its first index over fixed-length windows
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   synchronous active-high reset
//   bus    slave modport of nibble_mayor_window_if (sample stream in, result out)
// Parameter WINDOW (2..16): samples per window.
module nibble_mayor_window
  import nibble_mayor_window_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEFAULT
)
(
  input  logic                  clk,
  input  logic                  reset,
  nibble_mayor_window_if.slave  bus
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  nibble_t          run_max;
  logic [CNT_W-1:0] run_idx;

  nibble_t          sel_max;
  logic             sel_gt;
  nibble_t          new_max;
  logic [CNT_W-1:0] new_idx;
  logic             first;
  logic             accept;

  // While a result is held, a new sample may only enter in the same cycle the
  // result leaves, so the stream never stalls longer than the consumer does.
  assign bus.nmw_in_ready = (state == ST_ACCUM) ? 1'b1 : bus.nmw_max_ready;
  assign accept           = bus.nmw_in_valid && bus.nmw_in_ready;

  // The counter is zero both at the start of a window and while holding, so
  // it alone tells whether the incoming sample is index 0.
  assign first = (cnt == '0);

  nibble_max_sel u_max_sel (
    .cur_max (run_max),
    .sample  (bus.nmw_in),
    .greater (sel_max),
    .gt      (sel_gt)
  );

  // Index 0 loads unconditionally so a leftover running max never leaks in.
  always_comb begin
    new_max = sel_max;
    new_idx = run_idx;
    if (first) begin
      new_max = bus.nmw_in;
      new_idx = '0;
    end else if (sel_gt) begin
      new_idx = cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_ACCUM;
      cnt               <= '0;
      run_max           <= '0;
      run_idx           <= '0;
      bus.nmw_max       <= '0;
      bus.nmw_idx       <= '0;
      bus.nmw_max_valid <= 1'b0;
    end else begin
      if (state == ST_HOLD && bus.nmw_max_ready) begin
        state             <= ST_ACCUM;
        bus.nmw_max_valid <= 1'b0;
      end

      if (accept) begin
        if (state == ST_ACCUM && cnt == LAST) begin
          bus.nmw_max       <= new_max;
          bus.nmw_idx       <= NIBBLE_W'(new_idx);
          bus.nmw_max_valid <= 1'b1;
          cnt               <= '0;
          state             <= ST_HOLD;
        end else begin
          run_max <= new_max;
          run_idx <= new_idx;
          cnt     <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_mayor_window.sv
// tb/tb_nibble_mayor_window.sv - self-checking bench for nibble_mayor_window
module tb_nibble_mayor_window;

  localparam int WINDOW = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  nibble_mayor_window_if bus_if ();

  nibble_mayor_window #(.WINDOW(WINDOW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Window model: accepted samples are collected in a queue; a full queue
  // yields its maximum and the first position holding it.
  bit m_init  = 1'b0;
  bit m_valid = 1'b0;
  bit m_acc;
  int m_max   = 0;
  int m_idx   = 0;
  int win[$];

  always @(negedge clk) begin
    if (m_init) begin
      check("in_ready",  bus_if.nmw_in_ready, (!m_valid || bus_if.nmw_max_ready) ? 1 : 0);
      check("max_valid", bus_if.nmw_max_valid, int'(m_valid));
      check("max",       bus_if.nmw_max, m_max);
      check("idx",       bus_if.nmw_idx, m_idx);
    end
    if (reset) begin
      m_init  = 1'b1;
      m_valid = 1'b0;
      m_max   = 0;
      m_idx   = 0;
      win.delete();
    end else if (m_init) begin
      m_acc = bus_if.nmw_in_valid && (!m_valid || bus_if.nmw_max_ready);
      if (m_valid && bus_if.nmw_max_ready) m_valid = 1'b0;
      if (m_acc) begin
        win.push_back(int'(bus_if.nmw_in));
        if (win.size() == WINDOW) begin
          m_max = win[0];
          m_idx = 0;
          for (int i = 1; i < WINDOW; i++) begin
            if (win[i] > m_max) begin
              m_max = win[i];
              m_idx = i;
            end
          end
          m_valid = 1'b1;
          win.delete();
        end
      end
    end
  end

  task automatic step(input bit v, input logic [3:0] d, input bit r);
    bus_if.nmw_in_valid  = v;
    bus_if.nmw_in        = d;
    bus_if.nmw_max_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input string tag, input int v, input int m, input int i);
    check({tag, "_valid"}, bus_if.nmw_max_valid, v);
    check({tag, "_max"},   bus_if.nmw_max, m);
    check({tag, "_idx"},   bus_if.nmw_idx, i);
  endtask

  initial begin
    reset = 1'b1;
    step(0, 4'h0, 0);
    step(0, 4'h0, 0);
    reset = 1'b0;
    expect_res("reset", 0, 0, 0);

    // tie on 9 keeps the earlier index
    step(1, 4'h3, 1);
    step(1, 4'h9, 1);
    step(1, 4'h2, 1);
    expect_res("w1_early", 0, 0, 0);
    step(1, 4'h9, 1);
    expect_res("w1", 1, 9, 1);
    step(0, 4'h0, 1);
    expect_res("w1_drop", 0, 9, 1);

    // all-zero window still loads index 0
    for (int k = 0; k < 4; k++) step(1, 4'h0, 1);
    expect_res("zeros", 1, 0, 0);
    step(0, 4'h0, 1);

    // F does not end the window early; consumer stalls while 7s are offered
    step(1, 4'h1, 0);
    step(1, 4'hF, 0);
    expect_res("f_no_end", 0, 0, 0);
    step(1, 4'h2, 0);
    step(1, 4'h3, 0);
    expect_res("hold", 1, 15, 1);
    for (int k = 0; k < 5; k++) begin
      step(1, 4'h7, 0);
      expect_res("hold_stall", 1, 15, 1);
      check("stall_in_ready", bus_if.nmw_in_ready, 0);
    end
    step(1, 4'h7, 1);
    expect_res("xfer", 0, 15, 1);
    step(1, 4'h0, 1);
    step(1, 4'h7, 1);
    step(1, 4'h1, 1);
    expect_res("after_stall", 1, 7, 0);

    // back-to-back ramp, no bubbles
    for (int k = 0; k < 16; k++) begin
      step(1, 4'(k), 1);
      if (k % 4 == 3) expect_res("ramp", 1, k, 3);
      else check("ramp_gap_valid", bus_if.nmw_max_valid, 0);
    end

    // reset mid-window discards 5,6
    step(1, 4'h5, 1);
    step(1, 4'h6, 1);
    reset = 1'b1;
    step(0, 4'h0, 0);
    reset = 1'b0;
    expect_res("mid_reset", 0, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 4'h1, 1);
    expect_res("ones", 1, 1, 0);

    // reset while holding drops the untransferred result
    reset = 1'b1;
    step(0, 4'h0, 0);
    reset = 1'b0;
    expect_res("hold_reset", 0, 0, 0);

    // gaps in valid; junk on the bus during gaps must be ignored
    step(1, 4'h8, 1);
    step(0, 4'hF, 1);
    step(1, 4'h4, 1);
    step(0, 4'hF, 1);
    step(1, 4'hC, 1);
    step(0, 4'hF, 1);
    expect_res("toggle_early", 0, 0, 0);
    step(1, 4'h2, 1);
    expect_res("toggle", 1, 12, 2);
    step(0, 4'h0, 1);
    step(0, 4'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
